// File: rtl/fpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sequencer_if
// Description : Request/response bundle between the EX stage and the FP
//               sequencer.
//               Request  : in_valid, in_ready, in_op[3:0], in_a[31:0],
//                          in_b[31:0], in_tag[TAG_W-1:0], flush
//               Response : out_valid, out_ready, out_data[31:0],
//                          out_tag[TAG_W-1:0], out_illegal
//               modport master : EX stage / result consumer side
//               modport slave  : sequencer side
// Revision    : 1.0  initial release
// ============================================================================
interface fpu_sequencer_if #(
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sequencer
// Description : Single-outstanding issue controller in front of dsp_float.
//               Accepts one FP op, drives registered operands into dsp_float
//               and holds them for the op's fixed latency, captures the
//               selected result bus and returns it with its tag over a
//               valid/ready handshake. in_ready doubles as the EX-stage stall.
// Ports       : clk                 clock, rising edge
//               rst                 asynchronous reset, active-low
//               bus (slave)         request/response handshake bundle
//               dsp_left_op/right   registered operands to dsp_float
//               dsp_*_res           the ten dsp_float result outputs
//               busy                sequencer not idle
// Revision    : 1.0  initial release
// ============================================================================
module fpu_sequencer #(
    parameter int LAT_ADDSUB = 3,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 12,
    parameter int LAT_SQRT   = 12,
    parameter int LAT_CMP    = 1,
    parameter int LAT_CVT    = 2,
    parameter int TAG_W      = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fpu_sequencer_if.slave   bus,
    output logic [31:0]      dsp_left_op,
    output logic [31:0]      dsp_right_op,
    input  wire logic [31:0] dsp_int_float_res,
    input  wire logic [31:0] dsp_float_int_res,
    input  wire logic [31:0] dsp_float_add_res,
    input  wire logic [31:0] dsp_float_sub_res,
    input  wire logic [31:0] dsp_float_mul_res,
    input  wire logic [31:0] dsp_float_div_res,
    input  wire logic [31:0] dsp_float_sqrt_res,
    input  wire logic        dsp_float_eq_res,
    input  wire logic        dsp_float_lt_res,
    input  wire logic        dsp_float_lte_res,
    output logic             busy
);

    localparam int C_MAX_AB   = (LAT_ADDSUB > LAT_MUL)  ? LAT_ADDSUB : LAT_MUL;
    localparam int C_MAX_DS   = (LAT_DIV    > LAT_SQRT) ? LAT_DIV    : LAT_SQRT;
    localparam int C_MAX_CC   = (LAT_CMP    > LAT_CVT)  ? LAT_CMP    : LAT_CVT;
    localparam int C_MAX_ABDS = (C_MAX_AB   > C_MAX_DS) ? C_MAX_AB   : C_MAX_DS;
    localparam int C_MAX_LAT  = (C_MAX_ABDS > C_MAX_CC) ? C_MAX_ABDS : C_MAX_CC;
    localparam int CNT_W      = $clog2(C_MAX_LAT) + 1;

    localparam logic [3:0] C_OP_FADD  = 4'd0;
    localparam logic [3:0] C_OP_FSUB  = 4'd1;
    localparam logic [3:0] C_OP_FMUL  = 4'd2;
    localparam logic [3:0] C_OP_FDIV  = 4'd3;
    localparam logic [3:0] C_OP_FSQRT = 4'd4;
    localparam logic [3:0] C_OP_FEQ   = 4'd5;
    localparam logic [3:0] C_OP_FLT   = 4'd6;
    localparam logic [3:0] C_OP_FLE   = 4'd7;
    localparam logic [3:0] C_OP_CVTSW = 4'd8;
    localparam logic [3:0] C_OP_CVTWS = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_left;
    logic [31:0]        r_right;
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic               r_out_illegal;

    logic [31:0]        w_result;
    logic               w_illegal;
    logic               w_accept;

    // Counter preload is latency minus one so that the capture edge lands
    // exactly LAT cycles after the accepting edge. Illegal ops take 1 cycle.
    function automatic logic [CNT_W-1:0] lat_preload(input logic [3:0] op);
        case (op)
            C_OP_FADD, C_OP_FSUB:           return CNT_W'(LAT_ADDSUB - 1);
            C_OP_FMUL:                      return CNT_W'(LAT_MUL - 1);
            C_OP_FDIV:                      return CNT_W'(LAT_DIV - 1);
            C_OP_FSQRT:                     return CNT_W'(LAT_SQRT - 1);
            C_OP_FEQ, C_OP_FLT, C_OP_FLE:   return CNT_W'(LAT_CMP - 1);
            C_OP_CVTSW, C_OP_CVTWS:         return CNT_W'(LAT_CVT - 1);
            default:                        return '0;
        endcase
    endfunction

    // Result select by the latched op; compare bits are zero-extended.
    always_comb begin
        w_result = '0;
        case (r_op)
            C_OP_FADD:  w_result = dsp_float_add_res;
            C_OP_FSUB:  w_result = dsp_float_sub_res;
            C_OP_FMUL:  w_result = dsp_float_mul_res;
            C_OP_FDIV:  w_result = dsp_float_div_res;
            C_OP_FSQRT: w_result = dsp_float_sqrt_res;
            C_OP_FEQ:   w_result = {31'd0, dsp_float_eq_res};
            C_OP_FLT:   w_result = {31'd0, dsp_float_lt_res};
            C_OP_FLE:   w_result = {31'd0, dsp_float_lte_res};
            C_OP_CVTSW: w_result = dsp_int_float_res;
            C_OP_CVTWS: w_result = dsp_float_int_res;
            default:    w_result = '0;
        endcase
    end

    assign w_illegal = (r_op > C_OP_CVTWS);

    // A flush in IDLE blocks acceptance for that cycle.
    assign bus.in_ready = (r_state == S_IDLE) && !bus.flush;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op          <= '0;
            r_tag         <= '0;
            r_left        <= '0;
            r_right       <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (bus.flush) begin
            // Kill whatever is in flight; operands keep their last value.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_left  <= bus.in_a;
                        r_right <= bus.in_b;
                        r_op    <= bus.in_op;
                        r_tag   <= bus.in_tag;
                        r_cnt   <= lat_preload(bus.in_op);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_out_data    <= w_illegal ? 32'd0 : w_result;
                        r_out_illegal <= w_illegal;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dsp_left_op     = r_left;
    assign dsp_right_op    = r_right;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_tag     = r_tag;
    assign bus.out_illegal = r_out_illegal;
    assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire
